// File: rtl/led_pattern_driver.sv
// Pattern source for a 4-LED bank (LED[5:2]): prescaled tick, debounced mode
// button, and four patterns (static, blink, walking one, off).
module led_pattern_driver #(
  parameter int         TICK_DIV        = 1000000,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [3:0] STATIC_PATTERN  = 4'b1010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic [5:2] LED,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_syncVld;
  logic          r_debLevel;
  logic [DW-1:0] r_debCnt;
  logic          r_armed;
  logic [DW-1:0] r_armCnt;
  logic [PW-1:0] r_presc;
  mode_e         r_mode;
  logic [5:2]    r_led;
  logic          r_tick;

  logic          w_btnS;
  logic          w_debRise;
  logic          w_advance;
  logic          w_wrap;
  mode_e         w_modeNext;
  logic [5:2]    w_ledNext;

  assign w_btnS    = r_sync2;
  assign w_debRise = w_btnS && !r_debLevel && (r_debCnt == DEB_MAX);
  // A level already high at reset release must be seen low first, so presses
  // only count once the button has been observed stably released.
  assign w_advance = w_debRise && r_armed;
  assign w_wrap    = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_STATIC;
    end else begin
      r_mode <= w_modeNext;
    end
  end

  always_comb begin
    w_modeNext = r_mode;
    w_ledNext  = r_led;
    if (w_advance) begin
      case (r_mode)
        MODE_STATIC: w_modeNext = MODE_BLINK;
        MODE_BLINK:  w_modeNext = MODE_WALK;
        MODE_WALK:   w_modeNext = MODE_OFF;
        MODE_OFF:    w_modeNext = MODE_STATIC;
        default:     w_modeNext = MODE_STATIC;
      endcase
      case (w_modeNext)
        MODE_STATIC: w_ledNext = STATIC_PATTERN;
        MODE_BLINK:  w_ledNext = STATIC_PATTERN;
        MODE_WALK:   w_ledNext = 4'b0001;
        MODE_OFF:    w_ledNext = 4'b0000;
        default:     w_ledNext = STATIC_PATTERN;
      endcase
    end else if (w_wrap) begin
      case (r_mode)
        MODE_STATIC: w_ledNext = STATIC_PATTERN;
        MODE_BLINK:  w_ledNext = ~r_led;
        MODE_WALK:   w_ledNext = {r_led[4:2], r_led[5]};
        MODE_OFF:    w_ledNext = 4'b0000;
        default:     w_ledNext = STATIC_PATTERN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_syncVld  <= 2'b00;
      r_debLevel <= 1'b0;
      r_debCnt   <= '0;
      r_armed    <= 1'b0;
      r_armCnt   <= '0;
    end else begin
      r_sync1   <= btn_in;
      r_sync2   <= r_sync1;
      r_syncVld <= {r_syncVld[0], 1'b1};

      if (w_btnS != r_debLevel) begin
        if (r_debCnt == DEB_MAX) begin
          r_debLevel <= w_btnS;
          r_debCnt   <= '0;
        end else begin
          r_debCnt <= r_debCnt + DW'(1);
        end
      end else begin
        r_debCnt <= '0;
      end

      // Reset values in the synchronizer are not real samples, so arming
      // waits until the pipeline holds genuine button observations.
      if (!r_armed && r_syncVld[1]) begin
        if (w_btnS) begin
          r_armCnt <= '0;
        end else if (r_armCnt == DEB_MAX) begin
          r_armed <= 1'b1;
        end else begin
          r_armCnt <= r_armCnt + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_led   <= STATIC_PATTERN;
      r_tick  <= 1'b0;
    end else begin
      if (w_advance || w_wrap) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_tick <= w_wrap && !w_advance;
      r_led  <= w_ledNext;
    end
  end

  assign LED  = r_led;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Edge numbers count rising edges after reset release; outputs sampled on negedges.
module tb_led_pattern_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic [5:2] LED;
  logic [1:0] mode;
  logic       tick;

  int nCompared   = 0;
  int nMismatched = 0;
  int edgeN       = 0;

  always #5 clk = ~clk;

  led_pattern_driver #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .STATIC_PATTERN (4'b1010)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in),
    .LED   (LED),
    .mode  (mode),
    .tick  (tick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)",
               tag, observed, expected, edgeN);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    edgeN++;
  endtask

  task automatic applyStimulus(input logic btn, input int cycles);
    btn_in = btn;
    repeat (cycles) nextCycle();
  endtask

  task automatic doReset();
    btn_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edgeN = 0;
  endtask

  // Button set after edge c is first sampled at c+1 and accepted at c+5.
  task automatic pressButton(input logic [1:0] expMode, input logic [3:0] expLed);
    logic [1:0] prevMode;
    prevMode = expMode - 2'd1;
    applyStimulus(1'b1, 4);
    checkOutput("press-latency-mode", 32'(mode), 32'(prevMode));
    applyStimulus(1'b1, 1);
    checkOutput("press-mode", 32'(mode), 32'(expMode));
    checkOutput("press-led", 32'(LED), 32'(expLed));
    checkOutput("press-no-tick", 32'(tick), 32'(1'b0));
    btn_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] walkSeq [0:4];
    logic [3:0] expLed;
    walkSeq[0] = 4'b0001;
    walkSeq[1] = 4'b0010;
    walkSeq[2] = 4'b0100;
    walkSeq[3] = 4'b1000;
    walkSeq[4] = 4'b0001;

    rst_n  = 1'b0;
    btn_in = 1'b0;

    // Reset values and idle behaviour
    doReset();
    checkOutput("reset-led", 32'(LED), 32'(4'b1010));
    checkOutput("reset-mode", 32'(mode), 32'(2'd0));
    checkOutput("reset-tick", 32'(tick), 32'(1'b0));
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      checkOutput("idle-tick", 32'(tick), 32'(edgeN % 4 == 0));
      checkOutput("idle-led", 32'(LED), 32'(4'b1010));
      checkOutput("idle-mode", 32'(mode), 32'(2'd0));
    end

    // Button high from edge 10: mode 1 at edge 14, blink steps at 18 and 22
    doReset();
    applyStimulus(1'b0, 9);
    applyStimulus(1'b1, 4);
    checkOutput("btn-mode-edge13", 32'(mode), 32'(2'd0));
    nextCycle();
    checkOutput("btn-mode-edge14", 32'(mode), 32'(2'd1));
    checkOutput("btn-led-edge14", 32'(LED), 32'(4'b1010));
    checkOutput("btn-tick-edge14", 32'(tick), 32'(1'b0));
    for (int e = 15; e <= 22; e++) begin
      nextCycle();
      expLed = (e >= 18 && e < 22) ? 4'b0101 : 4'b1010;
      checkOutput("blink-led", 32'(LED), 32'(expLed));
      checkOutput("blink-tick", 32'(tick), 32'(e == 18 || e == 22));
    end
    applyStimulus(1'b0, 8);
    checkOutput("release-no-effect", 32'(mode), 32'(2'd1));

    // Two-cycle glitch is ignored; three-cycle pulse is accepted
    doReset();
    applyStimulus(1'b0, 6);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2);
    checkOutput("glitch-cnt-peak", 32'(dut.r_debCnt), 32'(2'd2));
    nextCycle();
    checkOutput("glitch-cnt-clear", 32'(dut.r_debCnt), 32'(2'd0));
    applyStimulus(1'b0, 8);
    checkOutput("glitch-mode", 32'(mode), 32'(2'd0));
    checkOutput("glitch-cnt-idle", 32'(dut.r_debCnt), 32'(2'd0));
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 1);
    checkOutput("pulse3-before", 32'(mode), 32'(2'd0));
    nextCycle();
    checkOutput("pulse3-accepted", 32'(mode), 32'(2'd1));

    // Full mode cycle; the BLINK->WALK press lands on a prescaler wrap
    doReset();
    applyStimulus(1'b0, 6);
    pressButton(2'd1, 4'b1010);
    applyStimulus(1'b0, 7);
    checkOutput("blink-step", 32'(LED), 32'(4'b0101));
    pressButton(2'd2, 4'b0001);
    for (int s = 0; s < 4; s++) begin
      for (int j = 1; j <= 4; j++) begin
        nextCycle();
        if (j < 4) begin
          checkOutput("walk-hold-led", 32'(LED), 32'(walkSeq[s]));
          checkOutput("walk-hold-tick", 32'(tick), 32'(1'b0));
        end else begin
          checkOutput("walk-step-led", 32'(LED), 32'(walkSeq[s+1]));
          checkOutput("walk-step-tick", 32'(tick), 32'(1'b1));
        end
      end
    end
    pressButton(2'd3, 4'b0000);
    applyStimulus(1'b0, 8);
    checkOutput("off-led", 32'(LED), 32'(4'b0000));
    checkOutput("off-mode", 32'(mode), 32'(2'd3));
    pressButton(2'd0, 4'b1010);
    applyStimulus(1'b0, 4);
    checkOutput("wrap-static-led", 32'(LED), 32'(4'b1010));

    // Asynchronous reset mid-cycle in WALK with the button held
    doReset();
    applyStimulus(1'b0, 6);
    pressButton(2'd1, 4'b1010);
    applyStimulus(1'b0, 7);
    pressButton(2'd2, 4'b0001);
    applyStimulus(1'b0, 2);
    checkOutput("walk-pre-reset", 32'(LED), 32'(4'b0001));
    applyStimulus(1'b1, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async-reset-led", 32'(LED), 32'(4'b1010));
    checkOutput("async-reset-mode", 32'(mode), 32'(2'd0));
    checkOutput("async-reset-tick", 32'(tick), 32'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edgeN = 0;
    applyStimulus(1'b1, 10);
    checkOutput("held-after-reset-mode", 32'(mode), 32'(2'd0));
    checkOutput("held-after-reset-led", 32'(LED), 32'(4'b1010));
    applyStimulus(1'b0, 6);
    checkOutput("released-mode", 32'(mode), 32'(2'd0));
    pressButton(2'd1, 4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
